// File: rtl/dotp_job_loader.sv
// dotp_job_loader
// Upstream sequencer for the 4-bit dot-product accelerator. Takes a job
// (a length header followed by A/B nibble pairs) on a valid/ready stream,
// loads the accelerator through its WRITE/RUN/READ opcode bus, clears the
// result words, starts the run, and returns the 8-bit result (or a timeout
// error) on a valid/ready response port. Every output is a flop.

module dotp_job_loader #(
    parameter int VEC_MAX  = 16,
    parameter int ADDR_A   = 1,
    parameter int ADDR_B   = 17,
    parameter int ADDR_OUT = 33,
    parameter int TIMEOUT  = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       r_valid,
    input  logic       r_ready,
    output logic [7:0] r_data,
    output logic       r_err,
    output logic       acc_rst_n,
    output logic [1:0] acc_op,
    output logic [5:0] acc_addr,
    output logic [3:0] acc_wdata,
    input  logic [1:0] acc_state,
    input  logic [7:0] acc_result
);

    localparam int IDX_W = $clog2(VEC_MAX);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;

    localparam logic [1:0] ACC_RUNNING = 2'd1;
    localparam logic [1:0] ACC_DONE    = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARST,
        S_WR_LEN,
        S_GET,
        S_WR_A,
        S_WR_B,
        S_CLR0,
        S_CLR1,
        S_RUN,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [3:0]       len_raw;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] idx;
    logic [3:0]       b_nib;
    logic [TMO_W-1:0] tmo_cnt;

    // Job sequencer: every output is registered on the transition into the
    // state that needs it, so each state's outputs are visible for exactly
    // the cycles the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            s_ready   <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= 8'd0;
            r_err     <= 1'b0;
            acc_rst_n <= 1'b0;
            acc_op    <= OP_READ;
            acc_addr  <= 6'd0;
            acc_wdata <= 4'd0;
            len_raw   <= 4'd0;
            last_idx  <= '0;
            idx       <= '0;
            b_nib     <= 4'd0;
            tmo_cnt   <= '0;
        end else begin
            s_ready   <= 1'b0;
            acc_rst_n <= 1'b1;
            acc_op    <= OP_READ;
            acc_addr  <= 6'd0;
            acc_wdata <= 4'd0;

            case (state)
                S_IDLE: begin
                    if (s_valid && s_ready) begin
                        len_raw   <= s_data[3:0];
                        last_idx  <= (s_data[3:0] == 4'd0) ? IDX_W'(VEC_MAX - 1)
                                                           : IDX_W'(s_data[3:0] - 4'd1);
                        idx       <= '0;
                        acc_rst_n <= 1'b0;
                        state     <= S_ARST;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end

                S_ARST: begin
                    acc_op    <= OP_WRITE;
                    acc_addr  <= 6'd0;
                    acc_wdata <= len_raw;
                    state     <= S_WR_LEN;
                end

                S_WR_LEN: begin
                    s_ready <= 1'b1;
                    state   <= S_GET;
                end

                S_GET: begin
                    if (s_valid && s_ready) begin
                        acc_op    <= OP_WRITE;
                        acc_addr  <= 6'(ADDR_A) + 6'(idx);
                        acc_wdata <= s_data[7:4];
                        b_nib     <= s_data[3:0];
                        state     <= S_WR_A;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end

                S_WR_A: begin
                    acc_op    <= OP_WRITE;
                    acc_addr  <= 6'(ADDR_B) + 6'(idx);
                    acc_wdata <= b_nib;
                    state     <= S_WR_B;
                end

                S_WR_B: begin
                    if (idx == last_idx) begin
                        acc_op    <= OP_WRITE;
                        acc_addr  <= 6'(ADDR_OUT);
                        acc_wdata <= 4'd0;
                        state     <= S_CLR0;
                    end else begin
                        idx     <= idx + 1'b1;
                        s_ready <= 1'b1;
                        state   <= S_GET;
                    end
                end

                S_CLR0: begin
                    acc_op    <= OP_WRITE;
                    acc_addr  <= 6'(ADDR_OUT + 1);
                    acc_wdata <= 4'd0;
                    state     <= S_CLR1;
                end

                S_CLR1: begin
                    acc_op  <= OP_RUN;
                    tmo_cnt <= '0;
                    state   <= S_RUN;
                end

                S_RUN: begin
                    if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                        r_valid <= 1'b1;
                        r_err   <= 1'b1;
                        r_data  <= 8'd0;
                        state   <= S_RESP;
                    end else if (acc_state == ACC_RUNNING) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        state   <= S_WAIT;
                    end else begin
                        acc_op  <= OP_RUN;
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (tmo_cnt == TMO_W'(TIMEOUT)) begin
                        r_valid <= 1'b1;
                        r_err   <= 1'b1;
                        r_data  <= 8'd0;
                        state   <= S_RESP;
                    end else if (acc_state == ACC_DONE) begin
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                        r_data  <= acc_result;
                        state   <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
